// File: rtl/flash_burst_reader.sv
// Burst command engine in front of the SPI flash byte-read wrapper: fetches bytes one at a
// time, packs them little-endian into 32-bit words and queues them with last-word marking.
module flash_burst_reader #(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [23:0]      cmd_addr_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             abort_i,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic [23:0]      mem_addr_o,
    input  logic [7:0]       mem_rdata_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_data_o,
    output logic             out_last_o,
    output logic             busy_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, GAP, PUSH} state_t;

    state_t             state, state_next;
    logic [23:0]        cur_addr;
    logic [LEN_W-1:0]   words_left;
    logic [1:0]         byte_idx;
    logic               abort_pend;
    logic [31:0]        word;
    logic [32:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               cmd_fire, fifo_full, fifo_empty, push, pop, last_word;

    assign cmd_ready_o = (state == IDLE);
    assign cmd_fire    = cmd_valid_i & cmd_ready_o;
    assign fifo_full   = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty  = (count == '0);
    assign pop         = ~fifo_empty & out_ready_i;
    assign last_word   = (words_left == LEN_W'(1));

    assign mem_valid_o = (state == FETCH);
    assign mem_addr_o  = cur_addr;
    assign out_valid_o = ~fifo_empty;
    assign out_data_o  = fifo_empty ? 32'd0 : fifo_mem[rd_ptr][31:0];
    assign out_last_o  = fifo_empty ? 1'b0 : fifo_mem[rd_ptr][32];
    assign busy_o      = (state != IDLE) | ~fifo_empty;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire && cmd_len_i != '0)
                    state_next = FETCH;
            end
            FETCH: begin
                // An aborted request still runs to completion so the wrapper is never cut off.
                if (mem_ready_i) begin
                    if (abort_i || abort_pend)
                        state_next = IDLE;
                    else if (byte_idx == 2'd3)
                        state_next = PUSH;
                    else
                        state_next = GAP;
                end
            end
            GAP: begin
                state_next = abort_i ? IDLE : FETCH;
            end
            PUSH: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (!fifo_full) begin
                    push       = 1'b1;
                    state_next = last_word ? IDLE : FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state      <= IDLE;
            cur_addr   <= '0;
            words_left <= '0;
            byte_idx   <= '0;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_next;
            abort_pend <= (state == FETCH) && !mem_ready_i && (abort_i || abort_pend);
            if (state == IDLE && cmd_fire && cmd_len_i != '0) begin
                cur_addr   <= cmd_addr_i;
                words_left <= cmd_len_i;
                byte_idx   <= '0;
            end
            if (state == FETCH && mem_ready_i) begin
                cur_addr <= cur_addr + 24'd1;
                byte_idx <= byte_idx + 2'd1;
            end
            if (push)
                words_left <= words_left - LEN_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (abort_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + (PTR_W+1)'(1);
            else if (pop && !push)
                count <= count - (PTR_W+1)'(1);
        end
    end

    // Data path: byte assembly and FIFO storage carry no reset.
    always_ff @(posedge clk_i) begin
        if (state == FETCH && mem_ready_i)
            word[{byte_idx, 3'b000} +: 8] <= mem_rdata_i;
        if (push)
            fifo_mem[wr_ptr] <= {last_word, word};
    end
endmodule
